i2c_slave_regbank: RTL

- Parametrised I2C slave with an NUM_REGS x 8-bit register bank. Successor to the fixed 4-register slave handler.
- The USB-CDC command decoder drives its host side:
  - cmd 0x14 sets the slave address.
  - cmd 0x15 performs a burst write.
  - cmd 0x16 performs a burst upload, now with a base index and valid/ready backpressure.
- The I2C side supports multi-byte auto-increment reads and writes with pointer wrap.

---
 rtl/i2c_slave_regbank.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_regbank.sv
// I2C slave with a NUM_REGS x 8-bit register bank, a host write port and a valid/ready upload port.
// Defining I2C_SLAVE_GENERAL_CALL_EN makes address 0x00 (write only) behave as an own-address write.
module i2c_slave_regbank #(
    parameter int unsigned NUM_REGS     = 16,
    parameter int unsigned REG_AW       = 4,
    parameter logic [6:0]  DEFAULT_ADDR = 7'h24,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    input  logic              cfg_addr_valid,
    input  logic [6:0]        cfg_addr,
    input  logic              host_wr_en,
    input  logic [REG_AW-1:0] host_wr_idx,
    input  logic [7:0]        host_wr_data,
    input  logic              up_start,
    input  logic [REG_AW-1:0] up_base,
    input  logic [7:0]        up_len,
    output logic [7:0]        up_data,
    output logic              up_valid,
    input  logic              up_ready,
    output logic              up_busy,
    output logic              i2c_busy,
    output logic              i2c_wr_pulse,
    output logic [6:0]        slave_addr
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_REG, ST_REG_ACK,
        ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_MACK
    } state_e;

    localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NUM_REGS - 1);

    function automatic logic [REG_AW-1:0] idx_inc(input logic [REG_AW-1:0] idx);
        return (idx >= LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    // NOTE: clocked state is always assigned with <=; always_comb uses = on its _d variables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        sh_q, sh_d, tx_q, tx_d;
    logic              phase_q, phase_d, sda_oe_q, sda_oe_d, rw_q, rw_d, mack_q, mack_d;
    logic              busy_q, busy_d, wr_pulse_q, i2c_we, addr_hit;
    logic [REG_AW-1:0] ptr_q, ptr_d;
    logic [6:0]        slave_addr_q;
    logic [7:0]        rx_byte, ptr_byte;
    logic [7:0]        regs_q [NUM_REGS];

    assign rx_byte  = {sh_q, sda_s};
    assign ptr_byte = regs_q[ptr_q];

    always_comb begin
        addr_hit = (rx_byte[7:1] == slave_addr_q);
        if (rx_byte[7:1] == 7'h00) begin
`ifdef I2C_SLAVE_GENERAL_CALL_EN
            addr_hit = ~rx_byte[0];
`else
            addr_hit = 1'b0;
`endif
        end
    end

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        tx_d      = tx_q;
        phase_d   = phase_q;
        sda_oe_d  = sda_oe_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        mack_d    = mack_q;
        busy_d    = busy_q;
        i2c_we    = 1'b0;

        case (state_q)
            ST_ADDR, ST_REG, ST_WDATA: begin
                if (scl_rise) begin
                    sh_d      = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        phase_d = 1'b0;
                        if (state_q == ST_ADDR) begin
                            rw_d    = rx_byte[0];
                            state_d = addr_hit ? ST_ADDR_ACK : ST_IDLE;
                        end else if (state_q == ST_REG) begin
                            if (32'(rx_byte) < NUM_REGS) begin
                                ptr_d   = rx_byte[REG_AW-1:0];
                                state_d = ST_REG_ACK;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            i2c_we  = 1'b1;
                            ptr_d   = idx_inc(ptr_q);
                            state_d = ST_WDATA_ACK;
                        end
                    end
                end
            end
            // Ack slot: phase 0 until the ack-bit rising edge, phase 1 until the slot's closing fall.
            ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK, ST_RDATA_MACK: begin
                if (scl_rise) begin
                    phase_d = 1'b1;
                    mack_d  = ~sda_s;
                end else if (scl_fall && !phase_q) begin
                    sda_oe_d = (state_q != ST_RDATA_MACK);
                end else if (scl_fall) begin
                    sda_oe_d  = 1'b0;
                    bit_cnt_d = 3'd0;
                    phase_d   = 1'b0;
                    if (state_q == ST_ADDR_ACK && !rw_q) begin
                        state_d = ST_REG;
                    end else if (state_q == ST_ADDR_ACK || (state_q == ST_RDATA_MACK && mack_q)) begin
                        tx_d     = ptr_byte[6:0];
                        ptr_d    = idx_inc(ptr_q);
                        sda_oe_d = ~ptr_byte[7];
                        state_d  = ST_RDATA;
                    end else if (state_q == ST_RDATA_MACK) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WDATA;
                    end
                end
            end
            ST_RDATA: begin
                if (scl_rise) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        phase_d = 1'b0;
                        state_d = ST_RDATA_MACK;
                    end
                end else if (scl_fall) begin
                    tx_d     = {tx_q[5:0], 1'b0};
                    sda_oe_d = ~tx_q[6];
                end
            end
            default: ;
        endcase

        if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            sh_q         <= '0;
            tx_q         <= '0;
            phase_q      <= 1'b0;
            sda_oe_q     <= 1'b0;
            rw_q         <= 1'b0;
            mack_q       <= 1'b0;
            busy_q       <= 1'b0;
            wr_pulse_q   <= 1'b0;
            ptr_q        <= '0;
            slave_addr_q <= DEFAULT_ADDR;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sh_q       <= sh_d;
            tx_q       <= tx_d;
            phase_q    <= phase_d;
            sda_oe_q   <= sda_oe_d;
            rw_q       <= rw_d;
            mack_q     <= mack_d;
            busy_q     <= busy_d;
            wr_pulse_q <= i2c_we;
            ptr_q      <= ptr_d;
            if (cfg_addr_valid) slave_addr_q <= cfg_addr;
        end
    end

    // NOTE: the register bank is reset because its all-zero reset contents are visible to both hosts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
        end else begin
            if (host_wr_en && 32'(host_wr_idx) < NUM_REGS) regs_q[host_wr_idx] <= host_wr_data;
            // Issued last so an I2C store to the same index overrides the host write.
            if (i2c_we) regs_q[ptr_q] <= rx_byte;
        end
    end

    logic              up_busy_q, up_valid_q;
    logic [7:0]        up_data_q, up_cur_byte;
    logic [REG_AW-1:0] up_idx_q, up_idx_next;
    logic [8:0]        up_cnt_q;

    assign up_idx_next = idx_inc(up_idx_q);
    assign up_cur_byte = (32'(up_idx_q) < NUM_REGS) ? regs_q[up_idx_q] : 8'h00;

    // The presented byte is captured, so later writes only affect bytes not yet presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_busy_q  <= 1'b0;
            up_valid_q <= 1'b0;
            up_data_q  <= 8'h00;
            up_idx_q   <= '0;
            up_cnt_q   <= 9'd0;
        end else if (!up_busy_q) begin
            if (up_start) begin
                up_busy_q <= 1'b1;
                up_idx_q  <= up_base;
                up_cnt_q  <= (up_len == 8'd0) ? 9'd256 : {1'b0, up_len};
            end
        end else if (!up_valid_q) begin
            up_valid_q <= 1'b1;
            up_data_q  <= up_cur_byte;
        end else if (up_ready) begin
            if (up_cnt_q == 9'd1) begin
                up_valid_q <= 1'b0;
                up_busy_q  <= 1'b0;
            end else begin
                up_cnt_q  <= up_cnt_q - 9'd1;
                up_idx_q  <= up_idx_next;
                up_data_q <= regs_q[up_idx_next];
            end
        end
    end

    assign sda_oe       = sda_oe_q;
    assign i2c_busy     = busy_q;
    assign i2c_wr_pulse = wr_pulse_q;
    assign slave_addr   = slave_addr_q;
    assign up_data      = up_data_q;
    assign up_valid     = up_valid_q;
    assign up_busy      = up_busy_q;

endmodule
